// File: rtl/sale_dispense.sv
// Dispense back end: queues drink/change commands from the vending controller and runs them out to
// the drink motors and coin ejector over a strobe/ack handshake, tracking stock, coins and fault flags.
module sale_dispense #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOCK_INIT = 8,
    parameter int CNT_W      = 4,
    parameter int TMO_CYC    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       drinks_in,
    input  logic             change_in,
    input  logic             vend_ack,
    input  logic             coin_ack,
    input  logic             restock,
    input  logic             clr_flags,
    output logic             vend_5,
    output logic             vend_10,
    output logic             coin_eject,
    output logic [CNT_W-1:0] stock_5,
    output logic [CNT_W-1:0] stock_10,
    output logic [CNT_W-1:0] coins,
    output logic             busy,
    output logic             overflow,
    output logic             err,
    output logic             fault
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(STOCK_INIT);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE, HALT} state_t;

    state_t           state_q, state_d;
    logic             vend_5_q, vend_5_d, vend_10_q, vend_10_d, coin_eject_q, coin_eject_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             chg_pend_q, chg_pend_d;
    logic [CNT_W-1:0] stock_5_q, stock_5_d, stock_10_q, stock_10_d, coins_q, coins_d;
    logic             overflow_q, overflow_d, err_q, err_d, fault_q, fault_d, busy_q, busy_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic [2:0]       mem_q [FIFO_DEPTH];

    logic             req_s, full_s, push_s, pop_s, err_set_s, fault_set_s;
    logic [2:0]       entry_s, head_s;

    assign req_s   = (drinks_in != 2'd0) || change_in;
    assign full_s  = (count_q == DEPTH_C);
    assign push_s  = req_s && !full_s;
    assign entry_s = {(drinks_in == 2'd3) ? 2'd0 : drinks_in, change_in};
    assign head_s  = mem_q[rd_q];
    assign pop_s   = (state_q == IDLE) && (count_q != '0) && !fault_q;

    // Next-state for sequencer, counters, queue pointers and sticky flags
    always_comb begin
        state_d      = state_q;
        vend_5_d     = vend_5_q;
        vend_10_d    = vend_10_q;
        coin_eject_d = coin_eject_q;
        timer_d      = timer_q;
        chg_pend_d   = chg_pend_q;
        stock_5_d    = stock_5_q;
        stock_10_d   = stock_10_q;
        coins_d      = coins_q;
        err_set_s    = (drinks_in == 2'd3);
        fault_set_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    chg_pend_d = head_s[0];
                    timer_d    = '0;
                    if ((head_s[2:1] == 2'd1) && (stock_5_q != '0)) begin
                        state_d  = VEND;
                        vend_5_d = 1'b1;
                    end else if ((head_s[2:1] == 2'd2) && (stock_10_q != '0)) begin
                        state_d   = VEND;
                        vend_10_d = 1'b1;
                    end else begin
                        // Sold-out drink is skipped but its change part still runs
                        if (head_s[2:1] != 2'd0) begin
                            err_set_s = 1'b1;
                        end else begin
                            err_set_s = err_set_s;
                        end
                        if (head_s[0] && (coins_q != '0)) begin
                            state_d      = CHANGE;
                            coin_eject_d = 1'b1;
                        end else if (head_s[0]) begin
                            err_set_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            VEND: begin
                if (vend_ack) begin
                    vend_5_d  = 1'b0;
                    vend_10_d = 1'b0;
                    if (vend_5_q) begin
                        stock_5_d = stock_5_q - CNT_W'(1);
                    end else begin
                        stock_10_d = stock_10_q - CNT_W'(1);
                    end
                    // CHANGE is entered with the ejector still low, giving the one-cycle gap
                    if (chg_pend_q && (coins_q != '0)) begin
                        state_d = CHANGE;
                    end else begin
                        state_d   = IDLE;
                        err_set_s = err_set_s | chg_pend_q;
                    end
                end else if (timer_q == TMO_LAST) begin
                    vend_5_d    = 1'b0;
                    vend_10_d   = 1'b0;
                    fault_set_s = 1'b1;
                    state_d     = HALT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHANGE: begin
                if (!coin_eject_q) begin
                    coin_eject_d = 1'b1;
                    timer_d      = '0;
                end else if (coin_ack) begin
                    coin_eject_d = 1'b0;
                    coins_d      = coins_q - CNT_W'(1);
                    state_d      = IDLE;
                end else if (timer_q == TMO_LAST) begin
                    coin_eject_d = 1'b0;
                    fault_set_s  = 1'b1;
                    state_d      = HALT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HALT: begin
                if (clr_flags) begin
                    state_d = IDLE;
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restock) begin
            stock_5_d  = INIT_C;
            stock_10_d = INIT_C;
            coins_d    = INIT_C;
        end else begin
            stock_5_d  = stock_5_d;
        end

        if (push_s) begin
            wr_d = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        count_d = count_q + (AW + 1)'(push_s) - (AW + 1)'(pop_s);

        overflow_d = (overflow_q && !clr_flags) || (req_s && full_s);
        err_d      = (err_q && !clr_flags) || err_set_s;
        fault_d    = (fault_q && !clr_flags) || fault_set_s;
        busy_d     = (state_d != IDLE) || (count_d != '0);
    end

    // Sequencer, counter, pointer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vend_5_q     <= 1'b0;
            vend_10_q    <= 1'b0;
            coin_eject_q <= 1'b0;
            timer_q      <= '0;
            chg_pend_q   <= 1'b0;
            stock_5_q    <= INIT_C;
            stock_10_q   <= INIT_C;
            coins_q      <= INIT_C;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
            fault_q      <= 1'b0;
            busy_q       <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            vend_5_q     <= vend_5_d;
            vend_10_q    <= vend_10_d;
            coin_eject_q <= coin_eject_d;
            timer_q      <= timer_d;
            chg_pend_q   <= chg_pend_d;
            stock_5_q    <= stock_5_d;
            stock_10_q   <= stock_10_d;
            coins_q      <= coins_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
            fault_q      <= fault_d;
            busy_q       <= busy_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
        end
    end

    // Command queue storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 3'b000;
            end
        end else if (push_s) begin
            mem_q[wr_q] <= entry_s;
        end
    end

    assign vend_5     = vend_5_q;
    assign vend_10    = vend_10_q;
    assign coin_eject = coin_eject_q;
    assign stock_5    = stock_5_q;
    assign stock_10   = stock_10_q;
    assign coins      = coins_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign err        = err_q;
    assign fault      = fault_q;
endmodule
